// File: rtl/posi_md_pp_ram_pkg.sv
// -----------------------------------------------------------------------------
// posi_md_pp_ram_pkg
// Shared definitions for the ping-pong mode RAM slice.
//   MD_DAT_WD  : width of one per-position mode entry
//   MD_CLR_VAL : "invalid mode" encoding written by the clear sequencer
//   clr_state_e: clear sequencer states
// -----------------------------------------------------------------------------
package posi_md_pp_ram_pkg;

    localparam int MD_DAT_WD = 6;

    localparam logic [MD_DAT_WD-1:0] MD_CLR_VAL = 6'h00;

    typedef enum logic {
        IDLE = 1'b0,
        CLR  = 1'b1
    } clr_state_e;

endpackage

// File: rtl/posi_md_ram_bank.sv
// -----------------------------------------------------------------------------
// posi_md_ram_bank
// One single-port bank with low-active chip/write enables. Payload is
// zero-padded up to the macro word width on write and stripped on read.
// Read data appears one cycle after a read access (cen=0, wen=1) and holds
// until the next read access.
// Ports:
//   clk   : clock, rising edge
//   cen   : chip enable, low active
//   wen   : write enable, low active (only meaningful while cen=0)
//   adr   : word address
//   dat_i : write payload
//   dat_o : read payload (registered)
// -----------------------------------------------------------------------------
module posi_md_ram_bank #(
    parameter int ADR_WD  = 6,
    parameter int DAT_WD  = 6,
    parameter int WORD_WD = 8
) (
    input  logic              clk,
    input  logic              cen,
    input  logic              wen,
    input  logic [ADR_WD-1:0] adr,
    input  logic [DAT_WD-1:0] dat_i,
    output logic [DAT_WD-1:0] dat_o
);

    logic [WORD_WD-1:0] word_i;
    logic [WORD_WD-1:0] word_o;
    logic               unused_pad;

    assign word_i = WORD_WD'(dat_i);

`ifdef XM_MODEL
    sram_sp_hde #(
        .ADR_WD  (ADR_WD),
        .WORD_WD (WORD_WD)
    ) u_macro (
        .CLK (clk),
        .CEN (cen),
        .WEN (wen),
        .A   (adr),
        .D   (word_i),
        .Q   (word_o)
    );
`else
    logic [WORD_WD-1:0] mem [2**ADR_WD];

    always_ff @(posedge clk) begin
        if (!cen) begin
            if (!wen) begin
                mem[adr] <= word_i;
            end else begin
                word_o <= mem[adr];
            end
        end
    end
`endif

    // Pad bits are always zero; they are not part of the payload.
    assign unused_pad = ^(word_o >> DAT_WD);
    assign dat_o      = word_o[DAT_WD-1:0];

endmodule

// File: rtl/posi_md_pp_ram.sv
// -----------------------------------------------------------------------------
// posi_md_pp_ram
// Ping-pong mode RAM between mode decision (producer) and per-LCU consumers.
// Bank bank_o takes producer writes and clear writes; bank ~bank_o serves
// consumer reads. A clear sequencer fills the producer bank with CLR_VAL over
// 2**ADR_WD cycles; swaps requested during a clear are deferred to the cycle
// in which done_o pulses.
// Ports:
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   swap_i    : pulse, exchange producer/consumer banks
//   clr_i     : pulse, clear the producer bank
//   wr_ena_i  : producer write enable, low active (dropped while busy_o)
//   wr_adr_i  : producer address
//   wr_dat_i  : producer data
//   rd_ena_i  : consumer read enable, low active
//   rd_adr_i  : consumer address
//   rd_dat_o  : read data, valid one cycle after the read, held otherwise
//   rd_val_o  : read data valid
//   bank_o    : producer bank index
//   busy_o    : clear in progress
//   done_o    : one-cycle pulse after the last clear write
// -----------------------------------------------------------------------------
module posi_md_pp_ram
    import posi_md_pp_ram_pkg::*;
#(
    parameter int                ADR_WD  = 6,
    parameter int                DAT_WD  = MD_DAT_WD,
    parameter int                WORD_WD = 8,
    parameter logic [DAT_WD-1:0] CLR_VAL = DAT_WD'(MD_CLR_VAL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              swap_i,
    input  logic              clr_i,
    input  logic              wr_ena_i,
    input  logic [ADR_WD-1:0] wr_adr_i,
    input  logic [DAT_WD-1:0] wr_dat_i,
    input  logic              rd_ena_i,
    input  logic [ADR_WD-1:0] rd_adr_i,
    output logic [DAT_WD-1:0] rd_dat_o,
    output logic              rd_val_o,
    output logic              bank_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADR_WD-1:0] ADR_LAST = {ADR_WD{1'b1}};

    clr_state_e        state_q;
    clr_state_e        state_d;
    logic [ADR_WD-1:0] clr_cnt_q;
    logic              prod_bank_q;
    logic              swap_pend_q;
    logic              done_q;
    logic              busy;
    logic              clr_last;
    logic              swap_go;

    logic              prod_we;
    logic [ADR_WD-1:0] prod_adr;
    logic [DAT_WD-1:0] prod_dat;

    logic              rd_val_p1;
    logic              rd_bank_p1;
    logic [DAT_WD-1:0] rd_hold_p1;
    logic [DAT_WD-1:0] rd_word;

    logic [1:0]        bank_cen;
    logic [1:0]        bank_wen;
    logic [ADR_WD-1:0] bank_adr [2];
    logic [DAT_WD-1:0] bank_rd  [2];

    assign busy     = (state_q == CLR);
    // Last address is found by comparison so the counter never relies on wrap.
    assign clr_last = busy && (clr_cnt_q == ADR_LAST);
    // A deferred swap fires in the done_o cycle; a fresh request in that same
    // cycle merges with it rather than toggling twice.
    assign swap_go  = (swap_i && !busy) || (swap_pend_q && done_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clr_i) state_d = CLR;
            CLR:     if (clr_cnt_q == ADR_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            clr_cnt_q   <= '0;
            prod_bank_q <= 1'b0;
            swap_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= busy ? clr_cnt_q + ADR_WD'(1) : '0;
            done_q      <= clr_last;
            prod_bank_q <= prod_bank_q ^ swap_go;
            if (swap_i && busy) begin
                swap_pend_q <= 1'b1;
            end else if (done_q) begin
                swap_pend_q <= 1'b0;
            end
        end
    end

    // Producer side: the clear sequencer owns the write port while busy.
    assign prod_we  = busy || !wr_ena_i;
    assign prod_adr = busy ? clr_cnt_q : wr_adr_i;
    assign prod_dat = busy ? CLR_VAL : wr_dat_i;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic is_prod;
        logic ren_n;

        assign is_prod     = (prod_bank_q == 1'(b));
        assign bank_wen[b] = !(is_prod && prod_we);
        assign ren_n       = !(!is_prod && !rd_ena_i);
        assign bank_cen[b] = bank_wen[b] && ren_n;
        assign bank_adr[b] = is_prod ? prod_adr : rd_adr_i;

        posi_md_ram_bank #(
            .ADR_WD  (ADR_WD),
            .DAT_WD  (DAT_WD),
            .WORD_WD (WORD_WD)
        ) u_bank (
            .clk   (clk),
            .cen   (bank_cen[b]),
            .wen   (bank_wen[b]),
            .adr   (bank_adr[b]),
            .dat_i (prod_dat),
            .dat_o (bank_rd[b])
        );
    end

    // ---- stage p1: read data returns from the bank that was consumer at issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_val_p1  <= 1'b0;
            rd_bank_p1 <= 1'b0;
            rd_hold_p1 <= '0;
        end else begin
            rd_val_p1 <= !rd_ena_i;
            if (!rd_ena_i) begin
                rd_bank_p1 <= !prod_bank_q;
            end
            if (rd_val_p1) begin
                rd_hold_p1 <= rd_word;
            end
        end
    end

    assign rd_word  = bank_rd[rd_bank_p1];
    assign rd_dat_o = rd_val_p1 ? rd_word : rd_hold_p1;
    assign rd_val_o = rd_val_p1;
    assign bank_o   = prod_bank_q;
    assign busy_o   = busy;
    assign done_o   = done_q;

endmodule

// File: tb/tb_posi_md_pp_ram.sv
module tb_posi_md_pp_ram;

    localparam int         DEPTH = 64;
    localparam logic [5:0] CLRV  = 6'h11;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       swap_i   = 1'b0;
    logic       clr_i    = 1'b0;
    logic       wr_ena_i = 1'b1;
    logic [5:0] wr_adr_i = '0;
    logic [5:0] wr_dat_i = '0;
    logic       rd_ena_i = 1'b1;
    logic [5:0] rd_adr_i = '0;
    logic [5:0] rd_dat_o;
    logic       rd_val_o;
    logic       bank_o;
    logic       busy_o;
    logic       done_o;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: two banks of plain storage, a producer index, and a
    // countdown of remaining clear cycles.
    logic [5:0] m_mem [2][DEPTH];
    bit         m_bank;
    int         m_left;
    bit         m_pend;
    bit         m_done;
    bit         m_val;
    logic [5:0] m_dat;

    posi_md_pp_ram #(
        .ADR_WD  (6),
        .DAT_WD  (6),
        .WORD_WD (8),
        .CLR_VAL (CLRV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .swap_i   (swap_i),
        .clr_i    (clr_i),
        .wr_ena_i (wr_ena_i),
        .wr_adr_i (wr_adr_i),
        .wr_dat_i (wr_dat_i),
        .rd_ena_i (rd_ena_i),
        .rd_adr_i (rd_adr_i),
        .rd_dat_o (rd_dat_o),
        .rd_val_o (rd_val_o),
        .bank_o   (bank_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout need finish");
        $fatal(1);
    end

    task automatic model_reset();
        m_bank = 1'b0;
        m_left = 0;
        m_pend = 1'b0;
        m_done = 1'b0;
        m_val  = 1'b0;
        m_dat  = 6'h00;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++)
                m_mem[b][a] = 'x;
    endtask

    // Drive one cycle of inputs, advance the model by that cycle, then sample
    // 1 time unit after the rising edge.
    task automatic cyc(input bit sw, input bit cl, input bit wen, input logic [5:0] wa,
                       input logic [5:0] wd, input bit ren, input logic [5:0] ra);
        bit busy_now;
        bit go;
        bit done_next;
        swap_i   = sw;
        clr_i    = cl;
        wr_ena_i = wen;
        wr_adr_i = wa;
        wr_dat_i = wd;
        rd_ena_i = ren;
        rd_adr_i = ra;

        busy_now = (m_left > 0);
        if (busy_now)
            m_mem[m_bank][DEPTH - m_left] = CLRV;
        else if (!wen)
            m_mem[m_bank][wa] = wd;
        if (!ren) begin
            m_val = 1'b1;
            m_dat = m_mem[~m_bank][ra];
        end else begin
            m_val = 1'b0;
        end
        go = (sw && !busy_now) || (m_pend && m_done);
        if (sw && busy_now)
            m_pend = 1'b1;
        else if (m_done)
            m_pend = 1'b0;
        done_next = busy_now && (m_left == 1);
        if (busy_now)
            m_left = m_left - 1;
        else if (cl)
            m_left = DEPTH;
        m_done = done_next;
        if (go)
            m_bank = ~m_bank;

        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b1, 6'h00, 6'h00, 1'b1, 6'h00);
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({bank_o, busy_o, done_o, rd_val_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got bank/busy/done/val=%b need 0000",
                     {bank_o, busy_o, done_o, rd_val_o});
        end
        n_chk++;
        if (rd_dat_o !== 6'h00) begin
            n_fail++;
            $display("FAIL reset_rd_dat: got %h need 00", rd_dat_o);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_write_swap_read();
        cyc(1'b0, 1'b0, 1'b0, 6'd5, 6'h2A, 1'b1, 6'd0);
        n_chk++;
        if (bank_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wsr_bank_pre: got %b need 0", bank_o);
        end
        cyc(1'b1, 1'b0, 1'b1, 6'd0, 6'h00, 1'b1, 6'd0);
        cyc(1'b0, 1'b0, 1'b1, 6'd0, 6'h00, 1'b0, 6'd5);
        n_chk++;
        if ({rd_val_o, bank_o, rd_dat_o} !== {1'b1, 1'b1, 6'h2A}) begin
            n_fail++;
            $display("FAIL wsr_read: got val=%b bank=%b dat=%h need val=1 bank=1 dat=2a",
                     rd_val_o, bank_o, rd_dat_o);
        end
        idle();
        n_chk++;
        if ({rd_val_o, rd_dat_o} !== {1'b0, 6'h2A}) begin
            n_fail++;
            $display("FAIL wsr_hold: got val=%b dat=%h need val=0 dat=2a", rd_val_o, rd_dat_o);
        end
    endtask

    task automatic test_same_cycle();
        cyc(1'b0, 1'b0, 1'b0, 6'd63, 6'h0A, 1'b1, 6'd0);
        cyc(1'b1, 1'b0, 1'b1, 6'd0, 6'h00, 1'b1, 6'd0);
        cyc(1'b0, 1'b0, 1'b0, 6'd63, 6'h3F, 1'b0, 6'd63);
        n_chk++;
        if ({rd_val_o, rd_dat_o} !== {1'b1, 6'h0A}) begin
            n_fail++;
            $display("FAIL same_cycle_old: got val=%b dat=%h need val=1 dat=0a", rd_val_o, rd_dat_o);
        end
        cyc(1'b1, 1'b0, 1'b1, 6'd0, 6'h00, 1'b1, 6'd0);
        cyc(1'b0, 1'b0, 1'b1, 6'd0, 6'h00, 1'b0, 6'd63);
        n_chk++;
        if ({rd_val_o, rd_dat_o} !== {1'b1, 6'h3F}) begin
            n_fail++;
            $display("FAIL same_cycle_new: got val=%b dat=%h need val=1 dat=3f", rd_val_o, rd_dat_o);
        end
    endtask

    task automatic test_clear();
        int         k;
        int         ndone;
        logic [5:0] adrs [4];
        adrs = '{6'd0, 6'd31, 6'd63, 6'd7};
        cyc(1'b0, 1'b1, 1'b1, 6'd0, 6'h00, 1'b1, 6'd0);
        k     = 0;
        ndone = 0;
        while (busy_o === 1'b1 && k < 200) begin
            if (done_o === 1'b1) ndone++;
            if (k == 40)
                cyc(1'b0, 1'b0, 1'b0, 6'd7, 6'h05, 1'b1, 6'd0);
            else
                idle();
            k++;
        end
        n_chk++;
        if (k !== 64) begin
            n_fail++;
            $display("FAIL clear_busy_len: got %0d cycles need 64", k);
        end
        n_chk++;
        if (done_o !== 1'b1 || ndone != 0) begin
            n_fail++;
            $display("FAIL clear_done_at_end: got done=%b early_pulses=%0d need done=1 early=0",
                     done_o, ndone);
        end
        idle();
        n_chk++;
        if (done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_done_pulse: got %b need 0", done_o);
        end
        cyc(1'b1, 1'b0, 1'b1, 6'd0, 6'h00, 1'b1, 6'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 6'd0, 6'h00, 1'b0, adrs[i]);
            n_chk++;
            if ({rd_val_o, rd_dat_o} !== {1'b1, CLRV}) begin
                n_fail++;
                $display("FAIL clear_read a=%0d: got val=%b dat=%h need val=1 dat=%h",
                         adrs[i], rd_val_o, rd_dat_o, CLRV);
            end
        end
    endtask

    task automatic test_swap_during_clear();
        logic b0;
        int   k;
        int   nbad;
        b0 = bank_o;
        cyc(1'b0, 1'b1, 1'b1, 6'd0, 6'h00, 1'b1, 6'd0);
        k    = 0;
        nbad = 0;
        while (busy_o === 1'b1 && k < 200) begin
            if (bank_o !== b0) nbad++;
            if (k == 10 || k == 20)
                cyc(1'b1, 1'b0, 1'b1, 6'd0, 6'h00, 1'b1, 6'd0);
            else
                idle();
            k++;
        end
        n_chk++;
        if (k !== 64 || nbad != 0) begin
            n_fail++;
            $display("FAIL swap_defer_busy: got len=%0d bank_changes=%0d need len=64 changes=0", k, nbad);
        end
        n_chk++;
        if ({done_o, bank_o} !== {1'b1, b0}) begin
            n_fail++;
            $display("FAIL swap_defer_done: got done=%b bank=%b need done=1 bank=%b", done_o, bank_o, b0);
        end
        idle();
        n_chk++;
        if (bank_o !== ~b0) begin
            n_fail++;
            $display("FAIL swap_defer_toggle: got %b need %b", bank_o, ~b0);
        end
        idle();
        n_chk++;
        if (bank_o !== ~b0) begin
            n_fail++;
            $display("FAIL swap_defer_single: got %b need %b", bank_o, ~b0);
        end
    endtask

    task automatic test_reset_mid_clear();
        int k;
        cyc(1'b0, 1'b1, 1'b1, 6'd0, 6'h00, 1'b1, 6'd0);
        for (int i = 0; i < 30; i++)
            cyc(1'b0, 1'b0, 1'b1, 6'd0, 6'h00, 1'b0, 6'(i));
        n_chk++;
        if ({busy_o, rd_val_o, bank_o} !== 3'b111) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got busy/val/bank=%b need 111", {busy_o, rd_val_o, bank_o});
        end
        rd_ena_i = 1'b1;
        rst      = 1'b1;
        #1;
        n_chk++;
        if ({busy_o, bank_o, rd_val_o, done_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid_async: got busy/bank/val/done=%b need 0000",
                     {busy_o, bank_o, rd_val_o, done_o});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        cyc(1'b0, 1'b1, 1'b1, 6'd0, 6'h00, 1'b1, 6'd0);
        k = 0;
        while (busy_o === 1'b1 && k < 200) begin
            idle();
            k++;
        end
        n_chk++;
        if (k !== 64 || done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_reclear: got len=%0d done=%b need len=64 done=1", k, done_o);
        end
    endtask

    task automatic test_random();
        bit         sw, cl, wen, ren;
        logic [5:0] wa, wd, ra;
        // Give both banks known contents first.
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < DEPTH; a++)
                cyc(1'b0, 1'b0, 1'b0, 6'(a), 6'($urandom), 1'b1, 6'd0);
            idle();
            cyc(1'b1, 1'b0, 1'b1, 6'd0, 6'h00, 1'b1, 6'd0);
        end
        for (int i = 0; i < 600; i++) begin
            sw  = ($urandom_range(0, 11) == 0);
            cl  = ($urandom_range(0, 99) == 0);
            wen = 1'($urandom_range(0, 1));
            ren = 1'($urandom_range(0, 1));
            wa  = 6'($urandom);
            wd  = 6'($urandom);
            ra  = 6'($urandom);
            cyc(sw, cl, wen, wa, wd, ren, ra);
            n_chk++;
            if ({bank_o, busy_o, done_o, rd_val_o} !== {m_bank, (m_left > 0), m_done, m_val}) begin
                n_fail++;
                $display("FAIL random_ctrl i=%0d: got bank/busy/done/val=%b need %b", i,
                         {bank_o, busy_o, done_o, rd_val_o}, {m_bank, (m_left > 0), m_done, m_val});
            end
            if (!$isunknown(m_dat)) begin
                n_chk++;
                if (rd_dat_o !== m_dat) begin
                    n_fail++;
                    $display("FAIL random_data i=%0d: got %h need %h", i, rd_dat_o, m_dat);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_swap_read();
        test_same_cycle();
        test_clear();
        test_swap_during_clear();
        test_reset_mid_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
